vtc_param: RTL and testbench

Parametrised video timing controller: the next generation of the fixed 640x480 `vtc`. Runs from a single clock, with a clock-enable so it can sit on the PLL pixel clock or on a faster system clock. Generates programmable horizontal and vertical timing, configurable sync polarities, active-video flags, pixel/line coordinates, and line/frame start strobes. Outputs feed the pattern generator and the VGA pins.

---
 rtl/vtc_param.sv | 99 +++++++++
 tb/tb_vtc_param.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/vtc_param.sv
`default_nettype none
// ============================================================================
// Module   : vtc_param
// Brief    : Parametrised video timing controller. It produces sync, active-video,
//            coordinate and line/frame strobe outputs that advance on clock-enable.
// Revision : 1.0 - initial release
// ============================================================================
module vtc_param #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ce,
    output logic          h_sync,
    output logic          v_sync,
    output logic          v_active,
    output logic [CW-1:0] h_pixel,
    output logic [CW-1:0] v_line,
    output logic          line_start,
    output logic          frame_start
);

    localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] c_h_max      = CW'(c_h_total - 1);
    localparam logic [CW-1:0] c_v_max      = CW'(c_v_total - 1);
    localparam logic [CW-1:0] c_h_act      = CW'(H_ACTIVE);
    localparam logic [CW-1:0] c_v_act      = CW'(V_ACTIVE);
    localparam logic [CW-1:0] c_hs_start   = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] c_hs_end     = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] c_vs_start   = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] c_vs_end     = CW'(V_ACTIVE + V_FP + V_SYNC);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_chk_regions
        $error("vtc_param: every timing region must be at least 1 wide");
    end

    if (CW < 1 || CW > 30 || c_h_total > (1 << CW) || c_v_total > (1 << CW)) begin : g_chk_width
        $error("vtc_param: CW too narrow for H_TOTAL/V_TOTAL");
    end

    logic [CW-1:0] r_h_cnt;
    logic [CW-1:0] r_v_cnt;

    logic w_h_wrap;
    logic w_v_wrap;
    logic w_in_hs;
    logic w_in_vs;
    logic w_active;

    assign w_h_wrap = (r_h_cnt == c_h_max);
    assign w_v_wrap = (r_v_cnt == c_v_max);
    assign w_in_hs  = (r_h_cnt >= c_hs_start) && (r_h_cnt < c_hs_end);
    assign w_in_vs  = (r_v_cnt >= c_vs_start) && (r_v_cnt < c_vs_end);
    assign w_active = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);

    // Outputs are the registered decode of the counters before they advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h_cnt     <= '0;
            r_v_cnt     <= '0;
            h_sync      <= ~HS_POL;
            v_sync      <= ~VS_POL;
            v_active    <= 1'b0;
            h_pixel     <= '0;
            v_line      <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (ce) begin
            h_sync      <= w_in_hs ? HS_POL : ~HS_POL;
            v_sync      <= w_in_vs ? VS_POL : ~VS_POL;
            v_active    <= w_active;
            h_pixel     <= r_h_cnt;
            v_line      <= r_v_cnt;
            line_start  <= (r_h_cnt == '0);
            frame_start <= (r_h_cnt == '0) && (r_v_cnt == '0);
            if (w_h_wrap) begin
                r_h_cnt <= '0;
                r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CW'(1);
            end else begin
                r_h_cnt <= r_h_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vtc_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_vtc_param
// Brief    : Bench for vtc_param: default 640x480 instance and a tiny 8x6 instance
//            checked every cycle against a frame-position reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vtc_param;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        va;
        logic        ls;
        logic        fs;
        logic [15:0] hp;
        logic [15:0] vl;
    } vid_t;

    logic clk;
    logic rst_n;
    logic ce;
    logic chk_on;
    int   k;
    int   n_cmp;
    int   n_bad;

    logic       def_hs, def_vs, def_va, def_ls, def_fs;
    logic [9:0] def_hp, def_vl;
    logic       sml_hs, sml_vs, sml_va, sml_ls, sml_fs;
    logic [3:0] sml_hp, sml_vl;

    vtc_param dut_def (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .h_sync(def_hs), .v_sync(def_vs), .v_active(def_va),
        .h_pixel(def_hp), .v_line(def_vl),
        .line_start(def_ls), .frame_start(def_fs)
    );

    vtc_param #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b0), .CW(4)
    ) dut_sml (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .h_sync(sml_hs), .v_sync(sml_vs), .v_active(sml_va),
        .h_pixel(sml_hp), .v_line(sml_vl),
        .line_start(sml_ls), .frame_start(sml_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // k = number of enabled clock edges since the last reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) k <= 0;
        else if (ce) k <= k + 1;
    end

    // Expected outputs after k enabled edges: the decode of raster position k-1.
    function automatic vid_t model(input int kk, input int ha, input int hf, input int hs,
                                   input int hb, input int va, input int vf, input int vs,
                                   input int vb, input bit hpol, input bit vpol);
        vid_t r;
        int ht, vt, p, x, y;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        if (kk == 0) begin
            r.hs = ~hpol; r.vs = ~vpol; r.va = 1'b0; r.ls = 1'b0; r.fs = 1'b0;
            r.hp = '0; r.vl = '0;
            return r;
        end
        p = (kk - 1) % (ht * vt);
        x = p % ht;
        y = p / ht;
        r.hs = (x >= ha + hf && x < ha + hf + hs) ? hpol : ~hpol;
        r.vs = (y >= va + vf && y < va + vf + vs) ? vpol : ~vpol;
        r.va = (x < ha) && (y < va);
        r.ls = (x == 0);
        r.fs = (p == 0);
        r.hp = 16'(x);
        r.vl = 16'(y);
        return r;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_vid(input string nm, input vid_t act, input vid_t exp);
        n_cmp = n_cmp + 1;
        if (act != exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got hs%0b vs%0b va%0b ls%0b fs%0b h%0d v%0d, expected hs%0b vs%0b va%0b ls%0b fs%0b h%0d v%0d (k=%0d t=%0t)",
                     nm, act.hs, act.vs, act.va, act.ls, act.fs, act.hp, act.vl,
                     exp.hs, exp.vs, exp.va, exp.ls, exp.fs, exp.hp, exp.vl, k, $time);
        end
    endtask

    always @(negedge clk) begin : compare
        vid_t a;
        if (chk_on) begin
            a = {def_hs, def_vs, def_va, def_ls, def_fs, 16'(def_hp), 16'(def_vl)};
            chk_vid("def_cycle", a, model(k, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0));
            a = {sml_hs, sml_vs, sml_va, sml_ls, sml_fs, 16'(sml_hp), 16'(sml_vl)};
            chk_vid("sml_cycle", a, model(k, 4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b0));
        end
    end

    task automatic chk_reset_now(input string nm);
        chk({nm, "_def_hs"}, int'(def_hs), 1);
        chk({nm, "_def_vs"}, int'(def_vs), 1);
        chk({nm, "_def_va"}, int'(def_va), 0);
        chk({nm, "_def_hp"}, int'(def_hp), 0);
        chk({nm, "_def_vl"}, int'(def_vl), 0);
        chk({nm, "_def_fs"}, int'(def_fs), 0);
        chk({nm, "_sml_hs"}, int'(sml_hs), 0);
        chk({nm, "_sml_vs"}, int'(sml_vs), 1);
        chk({nm, "_sml_ls"}, int'(sml_ls), 0);
    endtask

    task automatic chk_origin(input string nm);
        chk({nm, "_def_hp"}, int'(def_hp), 0);
        chk({nm, "_def_vl"}, int'(def_vl), 0);
        chk({nm, "_def_va"}, int'(def_va), 1);
        chk({nm, "_def_ls"}, int'(def_ls), 1);
        chk({nm, "_def_fs"}, int'(def_fs), 1);
        chk({nm, "_sml_fs"}, int'(sml_fs), 1);
    endtask

    initial begin : stim
        int c_def_hs_lo, c_def_va, c_def_ls;
        int c_sml_fs, c_sml_hs_hi, c_sml_vs_lo, c_sml_va;
        int rise0, rise1, n_rise, prev_fs;
        int bound;

        n_cmp = 0; n_bad = 0; chk_on = 1'b0;
        ce = 1'b0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        chk_on = 1'b1;

        // Reset held, ce high: nothing may move.
        ce = 1'b1;
        repeat (4) @(negedge clk);
        chk_reset_now("reset");

        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_origin("first_edge");

        // Continuous ce over pixels 0..1599.
        c_def_hs_lo = 0; c_def_va = 0; c_def_ls = 0;
        c_sml_fs = 0; c_sml_hs_hi = 0; c_sml_vs_lo = 0; c_sml_va = 0;
        for (int i = 0; i < 1600; i++) begin
            if (!def_hs) c_def_hs_lo++;
            if (def_va) c_def_va++;
            if (def_ls) c_def_ls++;
            if (sml_fs) c_sml_fs++;
            if (sml_hs) c_sml_hs_hi++;
            if (!sml_vs) c_sml_vs_lo++;
            if (sml_va) c_sml_va++;
            @(negedge clk);
        end
        chk("def_hsync_low_cycles", c_def_hs_lo, 192);
        chk("def_active_cycles", c_def_va, 1280);
        chk("def_line_starts", c_def_ls, 2);
        chk("sml_frame_starts", c_sml_fs, 34);
        chk("sml_hsync_high_cycles", c_sml_hs_hi, 400);
        chk("sml_vsync_low_cycles", c_sml_vs_lo, 264);
        chk("sml_active_cycles", c_sml_va, 404);

        // ce alternating 1,0: frame period doubles and strobes are held.
        rise0 = -1; rise1 = -1; n_rise = 0; prev_fs = int'(sml_fs);
        for (int i = 0; i < 2000; i++) begin
            ce = (i % 2 == 0);
            @(negedge clk);
            if (sml_fs && prev_fs == 0) begin
                if (n_rise == 0) rise0 = i;
                if (n_rise == 1) rise1 = i;
                n_rise++;
            end
            if (n_rise > 0 && i == ((n_rise == 1) ? rise0 : rise1) + 1)
                chk("sml_fs_held", int'(sml_fs), 1);
            prev_fs = int'(sml_fs);
        end
        chk("sml_fs_period_ce_half", rise1 - rise0, 96);

        // Random ce with occasional asynchronous resets between edges.
        for (int i = 0; i < 6000; i++) begin
            ce = ($urandom_range(3) != 0);
            if ($urandom_range(699) == 0) begin
                #2 rst_n = 1'b0;
                #1 chk_reset_now("rand_async_reset");
                @(negedge clk);
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
            @(negedge clk);
        end

        // Deterministic mid-frame reset at hPixel=300, vLine=2 of the default raster.
        ce = 1'b1;
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        bound = 0;
        while (!(def_hp == 10'd300 && def_vl == 10'd2) && bound < 5000) begin
            @(negedge clk);
            bound++;
        end
        chk("reach_300_2", (bound < 5000) ? 1 : 0, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset_now("midframe_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_origin("after_midframe_reset");
        repeat (100) @(negedge clk);

        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
